// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, oversampled start-bit
// qualification, mid-bit data/stop sampling and framing-error recovery.
module uart_rx #(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx_wire,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_error,
   output logic                 rx_busy
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER
   } state_e;

   logic                 rx_meta_q;
   logic                 rx_s_q;

   state_e               state_q,    state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_idx_q,  bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q,    shreg_d;
   logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_error_q, rx_error_d;

   // Synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_wire;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_error_q <= rx_error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_error_d = 1'b0;

      if (baud_tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d    = S_START;
                  tick_cnt_d = TW'(1);
               end
            end

            // Start bit must still be low half a bit time after the edge.
            S_START: begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  bit_idx_d  = '0;
                  state_d    = rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end

            S_DATA: begin
               if (tick_cnt_q == TICK_LAST) begin
                  shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                  tick_cnt_d = '0;
                  bit_idx_d  = bit_idx_q + BW'(1);
                  if (bit_idx_q == BIT_LAST) begin
                     bit_idx_d = '0;
                     state_d   = S_STOP;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end

            S_STOP: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (rx_s_q) begin
                     rx_data_d  = shreg_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     rx_error_d = 1'b1;
                     state_d    = S_RECOVER;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end

            // Wait for the line to return high so a break cannot re-trigger.
            S_RECOVER: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rx_busy = (state_q != S_IDLE);
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_error = rx_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line driver pushes expected
// strobes to a scoreboard, a monitor pops and compares them.
module tb_uart_rx;

   localparam int OVERSAMPLE = 8;
   localparam int DATA_BITS  = 8;
   localparam int TICK_DIV   = 8;
   localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

   logic                 clk;
   logic                 rst;
   logic                 baud_tick;
   logic                 rx_wire;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_error;
   logic                 rx_busy;

   typedef struct packed {
      logic                 err;
      logic [DATA_BITS-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tick_div_cnt = 0;

   uart_rx #(
      .OVERSAMPLE(OVERSAMPLE),
      .DATA_BITS (DATA_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_tick(baud_tick),
      .rx_wire  (rx_wire),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_error (rx_error),
      .rx_busy  (rx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
         baud_tick = (tick_div_cnt == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_error) check("both_strobes", 1, 0);
         if (rx_valid || rx_error) begin
            if (exp_q.size() == 0) begin
               check(rx_valid ? "unexpected_valid" : "unexpected_error", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("strobe_kind", {31'd0, rx_error}, {31'd0, e.err});
               check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
            end
         end
      end
   end

   task automatic drive_bit(input logic v);
      rx_wire = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DATA_BITS-1:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i]);
      drive_bit(stop);
      rx_wire = 1'b1;
   endtask

   task automatic send_good(input logic [DATA_BITS-1:0] b);
      exp_q.push_back('{err: 1'b0, data: b});
      send_frame(b, 1'b1);
   endtask

   initial begin
      rst     = 1'b1;
      rx_wire = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_rx_data",  {24'd0, rx_data}, 32'h0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
      check("reset_rx_error", {31'd0, rx_error}, 32'h0);
      check("reset_rx_busy",  {31'd0, rx_busy}, 32'h0);
      rst = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);

      // Single good frame.
      send_good(8'h55);
      repeat (TICK_DIV) @(negedge clk);
      check("good_busy_low", {31'd0, rx_busy}, 32'h0);
      check("good_rx_data",  {24'd0, rx_data}, 32'h55);

      // Back-to-back frames with no idle gap.
      send_good(8'hA3);
      send_good(8'h00);
      repeat (TICK_DIV) @(negedge clk);
      check("b2b_rx_data", {24'd0, rx_data}, 32'h00);

      // False start: two ticks low, then high.
      rx_wire = 1'b0;
      repeat (2 * TICK_DIV) @(negedge clk);
      rx_wire = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("false_start_busy", {31'd0, rx_busy}, 32'h0);
      check("false_start_data", {24'd0, rx_data}, 32'h00);

      send_good(8'h7E);
      repeat (TICK_DIV) @(negedge clk);

      // Framing error followed by a held-low line.
      exp_q.push_back('{err: 1'b1, data: 8'h7E});
      send_frame(8'h3C, 1'b0);
      rx_wire = 1'b0;
      repeat (20 * TICK_DIV) @(negedge clk);
      check("recover_busy_high", {31'd0, rx_busy}, 32'h1);
      check("recover_data_kept", {24'd0, rx_data}, 32'h7E);
      rx_wire = 1'b1;
      repeat (2 * TICK_DIV + 4) @(negedge clk);
      check("recover_busy_low", {31'd0, rx_busy}, 32'h0);
      send_good(8'h81);
      repeat (TICK_DIV) @(negedge clk);
      check("after_error_data", {24'd0, rx_data}, 32'h81);

      // Reset during data bit 4 of an aborted 0x5A frame.
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx_wire = 1'b1;
      repeat (20) @(negedge clk);
      check("midframe_busy", {31'd0, rx_busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_rx_data",  {24'd0, rx_data}, 32'h0);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'h0);
      check("midrst_rx_error", {31'd0, rx_error}, 32'h0);
      check("midrst_rx_busy",  {31'd0, rx_busy}, 32'h0);
      repeat (6 * BIT_CLKS) @(negedge clk);
      send_good(8'hF0);
      repeat (TICK_DIV) @(negedge clk);
      check("after_reset_data", {24'd0, rx_data}, 32'hF0);

      // Start edge at every phase relative to the tick grid.
      for (int p = 0; p < TICK_DIV; p++) begin
         repeat (p) @(negedge clk);
         send_good(8'h96);
         repeat (BIT_CLKS) @(negedge clk);
         check($sformatf("phase%0d_data", p), {24'd0, rx_data}, 32'h96);
         check($sformatf("phase%0d_busy", p), {31'd0, rx_busy}, 32'h0);
      end

      begin
         int waited;
         waited = 0;
         while (exp_q.size() != 0 && waited < 4 * BIT_CLKS) begin
            @(negedge clk);
            waited++;
         end
         check("scoreboard_drained", exp_q.size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
